// File: rtl/gbus_pkg.sv
// Shared gbus field widths and the write-beat record carried through the arbiter.
package gbus_pkg;

    localparam int BUS_CMEM_ADDR_WIDTH  = 13;
    localparam int BUS_CORE_ADDR_WIDTH  = 4;
    localparam int HEAD_SRAM_BIAS_WIDTH = 2;
    localparam int GBUS_ADDR_WIDTH      = HEAD_SRAM_BIAS_WIDTH + BUS_CORE_ADDR_WIDTH + BUS_CMEM_ADDR_WIDTH;
    localparam int GBUS_DATA_WIDTH      = 32;
    localparam int WR_W                 = GBUS_ADDR_WIDTH + GBUS_DATA_WIDTH;

    typedef struct packed {
        logic [GBUS_ADDR_WIDTH-1:0] addr;
        logic [GBUS_DATA_WIDTH-1:0] wdata;
    } gbus_wr_t;

endpackage

// File: rtl/gbus_wr_fifo.sv
// Per-core write FIFO; an extra pointer bit separates full from empty.
// Push and pop may coincide at any occupancy; the caller never pops when empty.
module gbus_wr_fifo
    import gbus_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    push_i,
    input  logic [WR_W-1:0]         push_data_i,
    input  logic                    pop_i,
    output logic [WR_W-1:0]         pop_data_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [$clog2(DEPTH):0]  count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WR_W-1:0]  mem_q [DEPTH];

    always_comb begin
        wr_ptr_d = push_i ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_i  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end

    assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];
    assign empty_o    = (wr_ptr_q == rd_ptr_q);
    assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o    = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/gbus_wr_arbiter.sv
// Funnels per-core gbus writes through per-core FIFOs onto one shared gbus,
// one beat per cycle, round-robin across cores.
module gbus_wr_arbiter
    import gbus_pkg::*;
#(
    parameter int NUM_REQ    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic [NUM_REQ-1:0]                    req_wen,
    input  logic [NUM_REQ*GBUS_ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*GBUS_DATA_WIDTH-1:0]    req_wdata,
    output logic                                  gbus_wen,
    output logic [GBUS_ADDR_WIDTH-1:0]            gbus_addr,
    output logic [GBUS_DATA_WIDTH-1:0]            gbus_wdata,
    output logic [NUM_REQ-1:0]                    ovf_flag,
    input  logic                                  ovf_clear,
    output logic                                  busy
);

    localparam int          PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int          CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned NREQ_U = NUM_REQ;

    // Requests have no ready: a write strobed into a full, unpopped FIFO is lost.
    logic [NUM_REQ-1:0] fifo_full, fifo_empty, fifo_push, fifo_pop, ovf_set;
    logic [WR_W-1:0]    fifo_dout [NUM_REQ];
    logic [CNT_W-1:0]   fifo_cnt  [NUM_REQ];

    logic               grant_vld;
    logic [PTR_W-1:0]   grant_idx;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    int unsigned        cand;
    logic               any_pend;

    logic               gbus_wen_q;
    gbus_wr_t           out_q;
    logic [NUM_REQ-1:0] ovf_q, ovf_d;
    logic               busy_q, busy_d;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_fifo
        gbus_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk         (clk),
            .rstn        (rstn),
            .push_i      (fifo_push[i]),
            .push_data_i ({req_addr[i*GBUS_ADDR_WIDTH +: GBUS_ADDR_WIDTH],
                           req_wdata[i*GBUS_DATA_WIDTH +: GBUS_DATA_WIDTH]}),
            .pop_i       (fifo_pop[i]),
            .pop_data_o  (fifo_dout[i]),
            .full_o      (fifo_full[i]),
            .empty_o     (fifo_empty[i]),
            .count_o     (fifo_cnt[i])
        );
    end

    // First non-empty FIFO scanning upward from rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = 0;
        for (int unsigned k = 0; k < NREQ_U; k++) begin
            cand = 32'(rr_ptr_q) + k;
            if (cand >= NREQ_U) cand = cand - NREQ_U;
            if (!grant_vld && !fifo_empty[PTR_W'(cand)]) begin
                grant_vld = 1'b1;
                grant_idx = PTR_W'(cand);
            end
        end
        fifo_pop = '0;
        if (grant_vld) fifo_pop[grant_idx] = 1'b1;
        rr_ptr_d = rr_ptr_q;
        if (grant_vld) rr_ptr_d = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end

    // A full FIFO still accepts a push in the cycle it is popped.
    assign fifo_push = req_wen & (~fifo_full | fifo_pop);
    assign ovf_set   = req_wen & fifo_full & ~fifo_pop;

    always_comb begin
        ovf_d    = (ovf_q & ~{NUM_REQ{ovf_clear}}) | ovf_set;
        any_pend = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (fifo_push[i] || (fifo_cnt[i] > CNT_W'(fifo_pop[i]))) any_pend = 1'b1;
        end
        busy_d = any_pend | grant_vld;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            gbus_wen_q <= 1'b0;
            out_q      <= '0;
            rr_ptr_q   <= '0;
            ovf_q      <= '0;
            busy_q     <= 1'b0;
        end else begin
            gbus_wen_q <= grant_vld;
            if (grant_vld) out_q <= gbus_wr_t'(fifo_dout[grant_idx]);
            rr_ptr_q   <= rr_ptr_d;
            ovf_q      <= ovf_d;
            busy_q     <= busy_d;
        end
    end

    assign gbus_wen   = gbus_wen_q;
    assign gbus_addr  = out_q.addr;
    assign gbus_wdata = out_q.wdata;
    assign ovf_flag   = ovf_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_gbus_wr_arbiter.sv
// Directed bench for gbus_wr_arbiter: latency, round-robin order, overflow,
// full push+pop and asynchronous reset mid-drain.
module tb_gbus_wr_arbiter;
    import gbus_pkg::*;

    localparam int N  = 16;
    localparam int AW = GBUS_ADDR_WIDTH;
    localparam int DW = GBUS_DATA_WIDTH;

    logic              clk = 1'b0;
    logic              rstn;
    logic [N-1:0]      req_wen;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_wdata;
    logic              gbus_wen;
    logic [AW-1:0]     gbus_addr;
    logic [DW-1:0]     gbus_wdata;
    logic [N-1:0]      ovf_flag;
    logic              ovf_clear;
    logic              busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] exp_q[$];
    logic [63:0] got_q[$];

    gbus_wr_arbiter #(.NUM_REQ(N), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_wen    (req_wen),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .gbus_wen   (gbus_wen),
        .gbus_addr  (gbus_addr),
        .gbus_wdata (gbus_wdata),
        .ovf_flag   (ovf_flag),
        .ovf_clear  (ovf_clear),
        .busy       (busy)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] ent(input logic [AW-1:0] a, input logic [DW-1:0] d);
        return 64'({a, d});
    endfunction

    function automatic logic [AW-1:0] a_of(input int c, input int b);
        return AW'(c * 8192 + b);
    endfunction

    function automatic logic [DW-1:0] d_of(input int c, input int b);
        return DW'(c * 256 + b);
    endfunction

    // bus monitor
    always @(negedge clk) begin
        if (rstn === 1'b1 && gbus_wen === 1'b1) got_q.push_back(ent(gbus_addr, gbus_wdata));
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input int c, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_wen[c]              = 1'b1;
        req_addr[c*AW +: AW]    = a;
        req_wdata[c*DW +: DW]   = d;
    endtask

    task automatic clr_wr();
        req_wen = '0;
    endtask

    task automatic single_drain(input int c);
        set_wr(c, a_of(c, 255), d_of(c, 255));
        tick();
        clr_wr();
        repeat (3) tick();
    endtask

    // scoreboard
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_beats(input string tag);
        chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk($sformatf("%s_beat%0d", tag, i), got_q[i], exp_q[i]);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        rstn      = 1'b0;
        req_wen   = '0;
        req_addr  = '0;
        req_wdata = '0;
        ovf_clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wen",   64'(gbus_wen),   64'd0);
        chk("rst_addr",  64'(gbus_addr),  64'd0);
        chk("rst_wdata", 64'(gbus_wdata), 64'd0);
        chk("rst_ovf",   64'(ovf_flag),   64'd0);
        chk("rst_busy",  64'(busy),       64'd0);
        rstn = 1'b1;
        tick();

        // single write from core 3
        set_wr(3, 19'h13005, 32'hDEADBEEF);
        tick();
        clr_wr();
        chk("t1_e0_wen",  64'(gbus_wen), 64'd0);
        chk("t1_e0_busy", 64'(busy),     64'd1);
        tick();
        chk("t1_e1_wen",   64'(gbus_wen),   64'd1);
        chk("t1_e1_addr",  64'(gbus_addr),  64'h13005);
        chk("t1_e1_wdata", 64'(gbus_wdata), 64'hDEADBEEF);
        chk("t1_e1_busy",  64'(busy),       64'd1);
        tick();
        chk("t1_e2_wen",  64'(gbus_wen),  64'd0);
        chk("t1_e2_busy", 64'(busy),      64'd0);
        chk("t1_e2_ovf",  64'(ovf_flag),  64'd0);
        chk("t1_e2_hold", 64'(gbus_addr), 64'h13005);

        // all 16 cores at once from rr_ptr=0
        single_drain(15);
        for (int i = 0; i < N; i++) set_wr(i, AW'(i), DW'(i));
        tick();
        clr_wr();
        for (int k = 0; k < N; k++) begin
            tick();
            chk($sformatf("t2_wen%0d", k),  64'(gbus_wen),   64'd1);
            chk($sformatf("t2_data%0d", k), 64'(gbus_wdata), 64'(k));
            chk($sformatf("t2_addr%0d", k), 64'(gbus_addr),  64'(k));
        end
        tick();
        chk("t2_end_wen",  64'(gbus_wen), 64'd0);
        chk("t2_end_busy", 64'(busy),     64'd0);
        set_wr(1, 19'd1, 32'h11);
        set_wr(0, 19'd0, 32'h10);
        tick();
        clr_wr();
        tick();
        chk("t2_rr0_first",  64'(gbus_wdata), 64'h10);
        tick();
        chk("t2_rr0_second", 64'(gbus_wdata), 64'h11);
        tick();

        // wrap: rr_ptr=14 after grant to 13, cores 2 and 15 pending
        single_drain(13);
        set_wr(2,  19'd2,  32'h2222);
        set_wr(15, 19'd15, 32'h1515);
        tick();
        clr_wr();
        tick();
        chk("t3_first",  64'(gbus_wdata), 64'h1515);
        tick();
        chk("t3_second", 64'(gbus_wdata), 64'h2222);
        tick();

        // overflow on core 5 while cores 0-4 burst
        single_drain(15);
        got_q.delete();
        for (int cyc = 0; cyc < 6; cyc++) begin
            clr_wr();
            if (cyc < 2) for (int c = 0; c < 5; c++) set_wr(c, a_of(c, cyc), d_of(c, cyc));
            set_wr(5, a_of(5, cyc), d_of(5, cyc));
            tick();
        end
        clr_wr();
        repeat (12) tick();
        for (int c = 0; c < 6; c++) exp_q.push_back(ent(a_of(c, 0), d_of(c, 0)));
        for (int c = 0; c < 6; c++) exp_q.push_back(ent(a_of(c, 1), d_of(c, 1)));
        exp_q.push_back(ent(a_of(5, 2), d_of(5, 2)));
        exp_q.push_back(ent(a_of(5, 3), d_of(5, 3)));
        chk("t4_ovf", 64'(ovf_flag), 64'h0020);
        check_beats("t4");
        ovf_clear = 1'b1;
        tick();
        ovf_clear = 1'b0;
        chk("t4_ovf_clr", 64'(ovf_flag), 64'd0);

        // FIFO 7 full, granted and pushed in the same cycle
        single_drain(7);
        got_q.delete();
        for (int cyc = 0; cyc < 5; cyc++) begin
            clr_wr();
            if (cyc == 0) for (int c = 8; c < 11; c++) set_wr(c, a_of(c, 0), d_of(c, 0));
            set_wr(7, a_of(7, cyc), d_of(7, cyc));
            tick();
        end
        clr_wr();
        repeat (10) tick();
        for (int c = 8; c < 11; c++) exp_q.push_back(ent(a_of(c, 0), d_of(c, 0)));
        for (int b = 0; b < 5; b++) exp_q.push_back(ent(a_of(7, b), d_of(7, b)));
        chk("t5_ovf", 64'(ovf_flag), 64'd0);
        check_beats("t5");

        // reset mid-drain after 4 of 10 beats
        got_q.delete();
        for (int cyc = 0; cyc < 4; cyc++) begin
            clr_wr();
            if (cyc < 3) for (int c = 1; c < 3; c++) set_wr(c, a_of(c, cyc), d_of(c, cyc));
            set_wr(0, a_of(0, cyc), d_of(0, cyc));
            tick();
        end
        clr_wr();
        tick();
        chk("t6_4th_wen", 64'(gbus_wen), 64'd1);
        @(negedge clk);
        #1;
        rstn = 1'b0;
        #1;
        chk("t6_rst_wen",  64'(gbus_wen),   64'd0);
        chk("t6_rst_busy", 64'(busy),       64'd0);
        chk("t6_rst_addr", 64'(gbus_addr),  64'd0);
        chk("t6_rst_data", 64'(gbus_wdata), 64'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (5) tick();
        chk("t6_quiet_wen",  64'(gbus_wen), 64'd0);
        chk("t6_quiet_busy", 64'(busy),     64'd0);
        exp_q.push_back(ent(a_of(0, 0), d_of(0, 0)));
        exp_q.push_back(ent(a_of(1, 0), d_of(1, 0)));
        exp_q.push_back(ent(a_of(2, 0), d_of(2, 0)));
        exp_q.push_back(ent(a_of(0, 1), d_of(0, 1)));
        check_beats("t6");
        set_wr(1, 19'd1, 32'hB1);
        set_wr(0, 19'd0, 32'hB0);
        tick();
        clr_wr();
        chk("t6_new_e0_wen", 64'(gbus_wen), 64'd0);
        tick();
        chk("t6_new_e1_wen",  64'(gbus_wen),   64'd1);
        chk("t6_new_rr0",     64'(gbus_wdata), 64'hB0);
        tick();
        chk("t6_new_second",  64'(gbus_wdata), 64'hB1);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
